// File: rtl/soundrive_i2s.sv
// Soundrive DAC mixer and I2S serializer: mixes l1+l2 / r1+r2 into 16-bit PCM and sends one L/R pair per 64-BCLK frame.
// Optional build macro SOUNDRIVE_DSM_EN adds first-order sigma-delta outputs dsm_l / dsm_r.
module soundrive_i2s (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic [7:0] l1,
    input  logic [7:0] l2,
    input  logic [7:0] r1,
    input  logic [7:0] r2,
    output logic       i2s_bclk,
    output logic       i2s_lrck,
    output logic       i2s_data,
    output logic       sample
`ifdef SOUNDRIVE_DSM_EN
    ,
    output logic       dsm_l,
    output logic       dsm_r
`endif
);

    logic [8:0]  sum_l;
    logic [8:0]  sum_r;
    logic [15:0] pcm_l;
    logic [15:0] pcm_r;

    // Unsigned 9-bit sum; flipping the top bit turns offset-binary into two's complement.
    assign sum_l = {1'b0, l1} + {1'b0, l2};
    assign sum_r = {1'b0, r1} + {1'b0, r2};
    assign pcm_l = {~sum_l[8], sum_l[7:0], 7'b0};
    assign pcm_r = {~sum_r[8], sum_r[7:0], 7'b0};

    logic        bclk_q, bclk_d;
    logic        lrck_q, lrck_d;
    logic        data_q, data_d;
    logic        sample_q, sample_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [15:0] hold_l_q, hold_l_d;
    logic [15:0] hold_r_q, hold_r_d;

    logic [5:0]  cnt_n;
    logic [4:0]  slot_pos;
    logic [4:0]  bit_idx;
    logic [15:0] slot_word;
    logic        slot_bit;

    always_comb begin
        cnt_n     = cnt_q + 6'd1;
        slot_pos  = cnt_n[4:0];
        bit_idx   = 5'd16 - slot_pos;
        slot_word = cnt_n[5] ? hold_r_q : hold_l_q;
        slot_bit  = 1'b0;
        if (slot_pos >= 5'd1 && slot_pos <= 5'd16) begin
            slot_bit = slot_word[bit_idx[3:0]];
        end
    end

    always_comb begin
        bclk_d   = bclk_q;
        lrck_d   = lrck_q;
        data_d   = data_q;
        sample_d = 1'b0;
        cnt_d    = cnt_q;
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        if (ce) begin
            bclk_d = ~bclk_q;
            // Everything framing-related moves only on the BCLK falling edge.
            if (bclk_q) begin
                cnt_d  = cnt_n;
                lrck_d = cnt_n[5];
                data_d = slot_bit;
                if (cnt_n == 6'd0) begin
                    hold_l_d = pcm_l;
                    hold_r_d = pcm_r;
                    sample_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bclk_q   <= 1'b0;
            lrck_q   <= 1'b0;
            data_q   <= 1'b0;
            sample_q <= 1'b0;
            cnt_q    <= 6'd0;
            hold_l_q <= 16'h0000;
            hold_r_q <= 16'h0000;
        end else begin
            bclk_q   <= bclk_d;
            lrck_q   <= lrck_d;
            data_q   <= data_d;
            sample_q <= sample_d;
            cnt_q    <= cnt_d;
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
        end
    end

    assign i2s_bclk = bclk_q;
    assign i2s_lrck = lrck_q;
    assign i2s_data = data_q;
    assign sample   = sample_q;

`ifdef SOUNDRIVE_DSM_EN
    logic [9:0] acc_l_q, acc_l_d;
    logic [9:0] acc_r_q, acc_r_d;

    // Bit 9 is the carry out of the previous add; it is dropped before the next accumulation.
    always_comb begin
        acc_l_d = {1'b0, acc_l_q[8:0]} + {1'b0, sum_l};
        acc_r_d = {1'b0, acc_r_q[8:0]} + {1'b0, sum_r};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_l_q <= 10'd0;
            acc_r_q <= 10'd0;
        end else begin
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
        end
    end

    assign dsm_l = acc_l_q[9];
    assign dsm_r = acc_r_q[9];
`endif

endmodule
